// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } fetch_entry_t;

endpackage

// File: rtl/pq_fifo.sv
// Prefetch FIFO of {instr, pc+4} plus an in-order PC tag ring, one tag per outstanding read.
// Latency: a push is visible at the head on the next cycle; clear empties it in one cycle.
// Backpressure: none internal; pushes while full are dropped, so the caller must hold credit.
module pq_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       tagAlloc,
    input  logic [31:0]                tagAddr,
    input  logic                       tagRelease,
    input  logic                       push,
    input  logic [31:0]                pushInstr,
    input  logic                       pop,
    output fetch_entry_t               headEntry,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  entries [DEPTH];
    logic [31:0]   tags    [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] tagWrPtr;
    logic [PW-1:0] tagRdPtr;
    logic          doPush;
    logic          doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign doPush    = push && !full && !clear;
    assign doPop     = pop && !empty && !clear;
    assign headEntry = entries[rdPtr];

    // The tag ring survives clear: wrong-path reads still return and must retire their tags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            tagWrPtr <= '0;
            tagRdPtr <= '0;
        end else begin
            if (clear) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (doPush) wrPtr <= nextPtr(wrPtr);
                if (doPop)  rdPtr <= nextPtr(rdPtr);
                count <= count + CW'(doPush) - CW'(doPop);
            end
            if (tagAlloc)   tagWrPtr <= nextPtr(tagWrPtr);
            if (tagRelease) tagRdPtr <= nextPtr(tagRdPtr);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush)   entries[wrPtr] <= '{instr: pushInstr, pcplus4: tags[tagRdPtr] + 32'd4};
        if (tagAlloc) tags[tagWrPtr] <= tagAddr;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue feeding IF/ID; optional FETCH_MISALIGN_CHK_EN flags misaligned redirects.
// Latency: response visible at head next cycle; redirect clears head next cycle.
// Backpressure: stall holds the head; requests are credit-limited to DEPTH words in flight plus buffered.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] InstructionF,
    output logic [31:0] PCPlus4F,
    output logic        inst_valid,
    output logic        misalign_err
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e state;
    logic [31:0]  pcQ;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [CW-1:0] dropOnRedirect;
    logic [31:0]  alignedTarget;
    logic         credit;
    logic         reqFire;
    logic         rspDrop;
    logic         pushEn;
    logic         popEn;
    logic         fifoFull;
    logic         fifoEmpty;
    fetch_entry_t headEntry;

    assign alignedTarget  = {redirect_pc[31:2], 2'b00};
    assign credit         = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH);
    assign imem_req_valid = (state == RUN) && !redirect && credit;
    assign imem_req_addr  = pcQ;
    assign reqFire        = imem_req_valid && imem_req_ready;
    // A response landing in the redirect cycle is wrong-path too, so it leaves drop.
    assign dropOnRedirect = inflight - CW'(imem_rsp_valid);
    assign rspDrop        = redirect || (drop != '0);
    assign pushEn         = imem_rsp_valid && !rspDrop && !fifoFull;
    assign popEn          = inst_valid && !stall && !redirect;

    assign inst_valid   = !fifoEmpty;
    assign InstructionF = fifoEmpty ? NOP_INSTR : headEntry.instr;
    assign PCPlus4F     = fifoEmpty ? 32'h0 : headEntry.pcplus4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pcQ      <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(reqFire) - CW'(imem_rsp_valid);
            if (redirect) begin
                pcQ   <= alignedTarget;
                drop  <= dropOnRedirect;
                state <= (dropOnRedirect != '0) ? DRAIN : RUN;
            end else begin
                case (state)
                    IDLE:    state <= RUN;
                    RUN:     if (reqFire) pcQ <= pcQ + 32'd4;
                    DRAIN: begin
                        if (imem_rsp_valid) begin
                            drop <= drop - 1'b1;
                            if (drop == CW'(1)) state <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_err <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`else
    logic unusedLowBits;
    assign unusedLowBits = ^redirect_pc[1:0];
    assign misalign_err  = 1'b0;
`endif

    pq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect),
        .tagAlloc   (reqFire),
        .tagAddr    (pcQ),
        .tagRelease (imem_rsp_valid),
        .push       (pushEn),
        .pushInstr  (imem_rsp_data),
        .pop        (popEn),
        .headEntry  (headEntry),
        .count      (count),
        .full       (fifoFull),
        .empty      (fifoEmpty)
    );

    rspOverflow: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rsp_valid && !rspDrop && fifoFull));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomised bench for fetch_prefetch_queue against a program-order fetch model and in-order memory.
module tb_fetch_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic [31:0] InstructionF;
    logic [31:0] PCPlus4F;
    logic        inst_valid;
    logic        misalign_err;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .InstructionF(InstructionF), .PCPlus4F(PCPlus4F), .inst_valid(inst_valid),
        .misalign_err(misalign_err)
    );

    typedef struct { logic [31:0] addr; int due; int epoch; } mem_req_t;
    mem_req_t pend[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0, epoch = 0, lastDue = 0, pops = 0;
    logic [31:0] expFetch = RESET_PC, expNext = RESET_PC;
    logic expMis = 1'b0, prevRedirect = 1'b0;
    logic stallIn = 1'b0, redirIn = 1'b0;
    logic [31:0] redirPcIn = '0;
    int readyPct = 100, latMin = 1, latMax = 1;
    logic sReqValid, sInstValid, sMis, sAccept;
    logic [31:0] sAddr, sInstr, sPc4, sAcceptAddr;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h0001_0003) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic rspDueNow();
        return (pend.size() > 0) && (pend[0].due <= cyc);
    endfunction

    function automatic int oldPending();
        int n = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) n++;
        return n;
    endfunction

    // One clock: drive at edge+1, sample and score at edge+2, return at next edge+1.
    task automatic cycle();
        logic rspNow;
        int lat, due;
        stall = stallIn;
        redirect = redirIn;
        redirect_pc = redirPcIn;
        imem_req_ready = (int'($urandom_range(0, 99)) < readyPct);
        rspNow = rspDueNow();
        imem_rsp_valid = rspNow;
        imem_rsp_data = rspNow ? memWord(pend[0].addr) : $urandom;
        #1;
        sReqValid = imem_req_valid; sAddr = imem_req_addr; sInstValid = inst_valid;
        sInstr = InstructionF; sPc4 = PCPlus4F; sMis = misalign_err;
        sAccept = imem_req_valid && imem_req_ready; sAcceptAddr = imem_req_addr;
        checks++;
        if (!inst_valid) begin
            if (InstructionF !== 32'h0 || PCPlus4F !== 32'h0) begin
                errors++;
                $display("FAIL empty_nop cyc=%0d instr=%h pc4=%h required 00000000/00000000", cyc, InstructionF, PCPlus4F);
            end
        end else if (PCPlus4F !== expNext + 32'd4 || InstructionF !== memWord(expNext)) begin
            errors++;
            $display("FAIL head_order cyc=%0d pc4=%h instr=%h required %h/%h", cyc, PCPlus4F, InstructionF, expNext + 32'd4, memWord(expNext));
        end
        if (prevRedirect) begin
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_clear cyc=%0d inst_valid=%b required 0", cyc, inst_valid);
            end
        end
        if (redirIn) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_no_req cyc=%0d req_valid=%b required 0", cyc, imem_req_valid);
            end
        end
        checks++;
        if (misalign_err !== expMis) begin
            errors++;
            $display("FAIL misalign_flag cyc=%0d got=%b required %b", cyc, misalign_err, expMis);
        end
        if (rspNow) void'(pend.pop_front());
        if (sAccept) begin
            checks++;
            if (imem_req_addr !== expFetch) begin
                errors++;
                $display("FAIL fetch_addr cyc=%0d addr=%h required %h", cyc, imem_req_addr, expFetch);
            end
            lat = int'($urandom_range(latMax, latMin));
            due = (cyc + lat < lastDue) ? lastDue : cyc + lat;
            lastDue = due;
            pend.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
            expFetch = imem_req_addr + 32'd4;
        end
        checks++;
        if (pend.size() > DEPTH) begin
            errors++;
            $display("FAIL credit cyc=%0d outstanding=%0d required <=%0d", cyc, pend.size(), DEPTH);
        end
        if (inst_valid && !stallIn && !redirIn) begin
            expNext = expNext + 32'd4;
            pops++;
        end
        if (redirIn) begin
            epoch++;
            expFetch = {redirPcIn[31:2], 2'b00};
            expNext = {redirPcIn[31:2], 2'b00};
            if (CHK_EN && redirPcIn[1:0] != 2'b00) expMis = 1'b1;
        end
        prevRedirect = redirIn;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic assertReset();
        rst = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        pend.delete(); lastDue = 0; epoch = 0;
        expFetch = RESET_PC; expNext = RESET_PC; expMis = 1'b0; prevRedirect = 1'b0;
        stallIn = 1'b0; redirIn = 1'b0; readyPct = 100; latMin = 1; latMax = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int firstValid = -1;
        assertReset();
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || inst_valid !== 1'b0 ||
            InstructionF !== 32'h0 || PCPlus4F !== 32'h0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values req=%b addr=%h iv=%b instr=%h pc4=%h mis=%b required 0/%h/0/0/0/0",
                     imem_req_valid, imem_req_addr, inst_valid, InstructionF, PCPlus4F, misalign_err, RESET_PC);
        end
        rst = 1'b1;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (sInstValid && firstValid < 0) firstValid = i;
            checks++;
            if (sReqValid !== (i >= 1)) begin
                errors++;
                $display("FAIL first_requests cycle=%0d req_valid=%b required %b", i, sReqValid, i >= 1);
            end
        end
        checks++;
        if (firstValid != 3) begin
            errors++;
            $display("FAIL first_valid_cycle got=%0d required 3", firstValid);
        end
    endtask

    task automatic test_sequential();
        int p0 = pops;
        repeat (40) cycle();
        checks++;
        if (pops - p0 != 40) begin
            errors++;
            $display("FAIL sequential_rate pops=%0d required 40", pops - p0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        int p0;
        for (int n = 0; n < 20 && !inst_valid; n++) cycle();
        stallIn = 1'b1;
        held = PCPlus4F;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (sInstValid !== 1'b1 || sPc4 !== held) begin
                errors++;
                $display("FAIL stall_hold step=%0d iv=%b pc4=%h required 1/%h", i, sInstValid, sPc4, held);
            end
        end
        checks++;
        if (sReqValid !== 1'b0) begin
            errors++;
            $display("FAIL stall_full_credit req_valid=%b required 0", sReqValid);
        end
        stallIn = 1'b0;
        p0 = pops;
        repeat (20) cycle();
        checks++;
        if (pops - p0 != 20) begin
            errors++;
            $display("FAIL stall_release_rate pops=%0d required 20", pops - p0);
        end
    endtask

    task automatic test_redirect_drain();
        int wrongLeft, idleCycles = 0, n = 0;
        logic expValid;
        latMin = 3; latMax = 3;
        while (pend.size() != 3 && n < 40) begin cycle(); n++; end
        checks++;
        if (pend.size() != 3) begin
            errors++;
            $display("FAIL drain_setup outstanding=%0d required 3", pend.size());
        end
        wrongLeft = pend.size() - (rspDueNow() ? 1 : 0);
        redirIn = 1'b1; redirPcIn = 32'h0000_0100;
        cycle();
        redirIn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            expValid = (oldPending() == 0);
            cycle();
            checks++;
            if (sReqValid !== expValid) begin
                errors++;
                $display("FAIL drain_req_valid step=%0d got=%b required %b", i, sReqValid, expValid);
            end
            if (sReqValid) break;
            idleCycles++;
        end
        checks++;
        if (idleCycles != wrongLeft) begin
            errors++;
            $display("FAIL drain_length got=%0d required %0d", idleCycles, wrongLeft);
        end
        for (int i = 0; i < 20 && !inst_valid; i++) cycle();
        checks++;
        if (PCPlus4F !== 32'h0000_0104) begin
            errors++;
            $display("FAIL drain_first_out pc4=%h required 00000104", PCPlus4F);
        end
        latMin = 1; latMax = 1;
    endtask

    task automatic test_redirect_same_cycle();
        for (int n = 0; n < 30 && !(inst_valid && rspDueNow()); n++) cycle();
        redirIn = 1'b1; redirPcIn = 32'h0000_0300;
        cycle();
        redirIn = 1'b0;
        cycle();
        checks++;
        if (sInstValid !== 1'b0 || sInstr !== 32'h0 || sPc4 !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_clear iv=%b instr=%h pc4=%h required 0/0/0", sInstValid, sInstr, sPc4);
        end
    endtask

    task automatic test_misalign();
        redirIn = 1'b1; redirPcIn = 32'h0000_0202;
        cycle();
        redirIn = 1'b0;
        sAccept = 1'b0;
        for (int n = 0; n < 20 && !sAccept; n++) cycle();
        checks++;
        if (sAccept !== 1'b1 || sAcceptAddr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL misalign_fetch accept=%b addr=%h required 1/00000200", sAccept, sAcceptAddr);
        end
        repeat (5) cycle();
        checks++;
        if (sMis !== CHK_EN) begin
            errors++;
            $display("FAIL misalign_sticky got=%b required %b", sMis, CHK_EN);
        end
    endtask

    task automatic test_ready_low();
        logic [31:0] held;
        readyPct = 0;
        for (int n = 0; n < 20 && !imem_req_valid; n++) cycle();
        held = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (sReqValid !== 1'b1 || sAddr !== held) begin
                errors++;
                $display("FAIL ready_low_stable step=%0d req=%b addr=%h required 1/%h", i, sReqValid, sAddr, held);
            end
        end
        readyPct = 100;
        cycle();
        checks++;
        if (sAccept !== 1'b1 || sAcceptAddr !== held) begin
            errors++;
            $display("FAIL ready_low_accept accept=%b addr=%h required 1/%h", sAccept, sAcceptAddr, held);
        end
    endtask

    task automatic test_random();
        int p0 = pops;
        readyPct = 70; latMin = 1; latMax = 4;
        for (int i = 0; i < 3000; i++) begin
            stallIn = (int'($urandom_range(0, 99)) < 30);
            redirIn = (int'($urandom_range(0, 99)) < 4);
            redirPcIn = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cycle();
        end
        stallIn = 1'b0; redirIn = 1'b0; readyPct = 100; latMin = 1; latMax = 1;
        checks++;
        if (pops - p0 < 300) begin
            errors++;
            $display("FAIL random_progress pops=%0d required >=300", pops - p0);
        end
    endtask

    task automatic test_midreset();
        int n = 0;
        readyPct = 80; latMin = 1; latMax = 3;
        redirIn = 1'b1; redirPcIn = 32'h0000_0403;
        cycle();
        redirIn = 1'b0;
        repeat (12) cycle();
        assertReset();
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || inst_valid !== 1'b0 ||
            InstructionF !== 32'h0 || PCPlus4F !== 32'h0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values req=%b addr=%h iv=%b instr=%h pc4=%h mis=%b required 0/%h/0/0/0/0",
                     imem_req_valid, imem_req_addr, inst_valid, InstructionF, PCPlus4F, misalign_err, RESET_PC);
        end
        rst = 1'b1;
        cyc = 0;
        while (!inst_valid && n < 20) begin cycle(); n++; end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL midreset_restart first_valid=%0d required 3", n);
        end
        repeat (10) cycle();
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_misalign();
        test_ready_low();
        test_random();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
